bp_cache_req_responder: RTL



---
 rtl/bp_cache_req_responder.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_cache_req_responder.sv
// Cache-side responder for one cache port: fills misses, services uncached
// accesses through a simple memory port, and clears tag/stat state after reset.
module bp_cache_req_responder #(
  parameter int paddr_width_p = 40,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512,
  parameter int dword_width_p = 64,
  parameter int ptag_width_p  = 28,
  localparam int lg_sets_lp      = $clog2(sets_p),
  localparam int lg_assoc_lp     = $clog2(assoc_p),
  localparam int block_offset_lp = $clog2(block_width_p / 8),
  localparam int cache_req_width_lp          = 2 + paddr_width_p + 3 + dword_width_p,
  localparam int cache_req_metadata_width_lp = lg_assoc_lp + 1,
  localparam int data_mem_pkt_width_lp = 2 + lg_sets_lp + lg_assoc_lp + block_width_p,
  localparam int tag_mem_pkt_width_lp  = 2 + lg_sets_lp + lg_assoc_lp + ptag_width_p + 2,
  localparam int stat_mem_pkt_width_lp = 2 + lg_sets_lp + lg_assoc_lp,
  localparam int mem_cmd_width_lp      = 2 + paddr_width_p + 3 + dword_width_p
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [cache_req_width_lp-1:0]          cache_req_i,
  input  logic                                   cache_req_v_i,
  output logic                                   cache_req_ready_o,
  input  logic [cache_req_metadata_width_lp-1:0] cache_req_metadata_i,
  input  logic                                   cache_req_metadata_v_i,
  output logic                                   cache_req_complete_o,
  output logic [data_mem_pkt_width_lp-1:0]       data_mem_pkt_o,
  output logic                                   data_mem_pkt_v_o,
  input  logic                                   data_mem_pkt_ready_i,
  output logic [tag_mem_pkt_width_lp-1:0]        tag_mem_pkt_o,
  output logic                                   tag_mem_pkt_v_o,
  input  logic                                   tag_mem_pkt_ready_i,
  output logic [stat_mem_pkt_width_lp-1:0]       stat_mem_pkt_o,
  output logic                                   stat_mem_pkt_v_o,
  input  logic                                   stat_mem_pkt_ready_i,
  output logic [mem_cmd_width_lp-1:0]            mem_cmd_o,
  output logic                                   mem_cmd_v_o,
  input  logic                                   mem_cmd_ready_i,
  input  logic [block_width_p-1:0]               mem_resp_i,
  input  logic                                   mem_resp_v_i,
  output logic                                   mem_resp_yumi_o
);

  typedef enum logic [3:0] {
    e_clear, e_ready, e_meta, e_mem_cmd, e_mem_resp, e_data, e_tag, e_stat, e_done
  } state_e;

  localparam logic [1:0] e_miss_load  = 2'd0;
  localparam logic [1:0] e_miss_store = 2'd1;
  localparam logic [1:0] e_uc_load    = 2'd2;
  localparam logic [1:0] e_uc_store   = 2'd3;

  localparam logic [1:0] e_cache_data_mem_write    = 2'd0;
  localparam logic [1:0] e_cache_data_mem_uncached = 2'd1;
  localparam logic [1:0] e_cache_tag_mem_set_clear = 2'd0;
  localparam logic [1:0] e_cache_tag_mem_set_tag   = 2'd1;
  localparam logic [1:0] e_cache_stat_mem_set_clear = 2'd0;

  localparam logic [1:0] e_state_invalid   = 2'd0;
  localparam logic [1:0] e_state_shared    = 2'd1;
  localparam logic [1:0] e_state_exclusive = 2'd2;

  state_e                   state_q, state_d;
  logic [lg_sets_lp-1:0]    idx_q, idx_d;
  logic                     tag_done_q, tag_done_d;
  logic                     stat_done_q, stat_done_d;
  logic [1:0]               msg_q, msg_d;
  logic [paddr_width_p-1:0] addr_q, addr_d;
  logic [2:0]               size_q, size_d;
  logic [dword_width_p-1:0] wdata_q, wdata_d;
  logic [lg_assoc_lp-1:0]   way_q, way_d;
  logic [block_width_p-1:0] blk_q, blk_d;

  logic [1:0]               req_msg;
  logic [paddr_width_p-1:0] req_addr;
  logic [2:0]               req_size;
  logic [dword_width_p-1:0] req_data;
  logic [lg_assoc_lp-1:0]   meta_way;
  logic                     unused_dirty;

  logic                     is_miss, is_uc_store, tag_fin, stat_fin;
  logic [lg_sets_lp-1:0]    fill_idx;
  logic [ptag_width_p-1:0]  fill_tag;
  logic [paddr_width_p-1:0] blk_addr;

  assign req_msg      = cache_req_i[cache_req_width_lp-1 -: 2];
  assign req_addr     = cache_req_i[dword_width_p+3 +: paddr_width_p];
  assign req_size     = cache_req_i[dword_width_p +: 3];
  assign req_data     = cache_req_i[dword_width_p-1:0];
  assign meta_way     = cache_req_metadata_i[lg_assoc_lp:1];
  // Write-through caches never need a writeback, so dirty carries no information.
  assign unused_dirty = cache_req_metadata_i[0];

  assign is_miss     = ~msg_q[1];
  assign is_uc_store = (msg_q == e_uc_store);
  assign fill_idx    = addr_q[block_offset_lp +: lg_sets_lp];
  assign fill_tag    = addr_q[paddr_width_p-1 -: ptag_width_p];
  assign blk_addr    = {addr_q[paddr_width_p-1:block_offset_lp], {block_offset_lp{1'b0}}};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tag_done_d  = tag_done_q;
    stat_done_d = stat_done_q;
    msg_d       = msg_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    way_d       = way_q;
    blk_d       = blk_q;
    tag_fin     = 1'b0;
    stat_fin    = 1'b0;

    cache_req_ready_o    = 1'b0;
    cache_req_complete_o = 1'b0;
    data_mem_pkt_v_o     = 1'b0;
    tag_mem_pkt_v_o      = 1'b0;
    stat_mem_pkt_v_o     = 1'b0;
    mem_cmd_v_o          = 1'b0;
    mem_resp_yumi_o      = 1'b0;
    data_mem_pkt_o = {e_cache_data_mem_write, fill_idx, way_q, blk_q};
    tag_mem_pkt_o  = {e_cache_tag_mem_set_tag, fill_idx, way_q, fill_tag, e_state_invalid};
    stat_mem_pkt_o = {e_cache_stat_mem_set_clear, fill_idx, way_q};
    mem_cmd_o      = {1'b0, 1'b0, blk_addr, 3'(block_offset_lp), {dword_width_p{1'b0}}};

    case (state_q)
      e_clear: begin
        // Tag and stat clears for a set handshake independently; the set advances once both are done.
        tag_mem_pkt_v_o  = ~tag_done_q;
        stat_mem_pkt_v_o = ~stat_done_q;
        tag_mem_pkt_o  = {e_cache_tag_mem_set_clear, idx_q, {lg_assoc_lp{1'b0}},
                          {ptag_width_p{1'b0}}, e_state_invalid};
        stat_mem_pkt_o = {e_cache_stat_mem_set_clear, idx_q, {lg_assoc_lp{1'b0}}};
        tag_fin  = tag_done_q | tag_mem_pkt_ready_i;
        stat_fin = stat_done_q | stat_mem_pkt_ready_i;
        if (tag_fin && stat_fin) begin
          tag_done_d  = 1'b0;
          stat_done_d = 1'b0;
          idx_d       = idx_q + 1'b1;
          if (idx_q == lg_sets_lp'(sets_p - 1)) begin
            idx_d   = '0;
            state_d = e_ready;
          end
        end else begin
          tag_done_d  = tag_fin;
          stat_done_d = stat_fin;
        end
      end
      e_ready: begin
        cache_req_ready_o = 1'b1;
        if (cache_req_v_i) begin
          msg_d   = req_msg;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_data;
          way_d   = '0;
          if (req_msg[1]) begin
            state_d = e_mem_cmd;
          end else if (cache_req_metadata_v_i) begin
            way_d   = meta_way;
            state_d = e_mem_cmd;
          end else begin
            state_d = e_meta;
          end
        end
      end
      e_meta: begin
        if (cache_req_metadata_v_i) begin
          way_d   = meta_way;
          state_d = e_mem_cmd;
        end
      end
      e_mem_cmd: begin
        mem_cmd_v_o = 1'b1;
        if (!is_miss) begin
          mem_cmd_o = {is_uc_store, 1'b1, addr_q, size_q, wdata_q};
        end
        if (mem_cmd_ready_i) begin
          state_d = e_mem_resp;
        end
      end
      e_mem_resp: begin
        if (mem_resp_v_i) begin
          mem_resp_yumi_o = 1'b1;
          blk_d   = is_miss ? mem_resp_i : block_width_p'(mem_resp_i[dword_width_p-1:0]);
          state_d = is_uc_store ? e_done : e_data;
        end
      end
      e_data: begin
        data_mem_pkt_v_o = 1'b1;
        data_mem_pkt_o   = {is_miss ? e_cache_data_mem_write : e_cache_data_mem_uncached,
                            fill_idx, way_q, blk_q};
        if (data_mem_pkt_ready_i) begin
          state_d = is_miss ? e_tag : e_done;
        end
      end
      e_tag: begin
        tag_mem_pkt_v_o = 1'b1;
        tag_mem_pkt_o   = {e_cache_tag_mem_set_tag, fill_idx, way_q, fill_tag,
                           (msg_q == e_miss_store) ? e_state_exclusive : e_state_shared};
        if (tag_mem_pkt_ready_i) begin
          state_d = e_stat;
        end
      end
      e_stat: begin
        stat_mem_pkt_v_o = 1'b1;
        if (stat_mem_pkt_ready_i) begin
          state_d = e_done;
        end
      end
      e_done: begin
        cache_req_complete_o = 1'b1;
        state_d = e_ready;
      end
      default: state_d = e_clear;
    endcase

    if (reset_i) begin
      cache_req_ready_o    = 1'b0;
      cache_req_complete_o = 1'b0;
      data_mem_pkt_v_o     = 1'b0;
      tag_mem_pkt_v_o      = 1'b0;
      stat_mem_pkt_v_o     = 1'b0;
      mem_cmd_v_o          = 1'b0;
      mem_resp_yumi_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_clear;
      idx_q       <= '0;
      tag_done_q  <= 1'b0;
      stat_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tag_done_q  <= tag_done_d;
      stat_done_q <= stat_done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    msg_q   <= msg_d;
    addr_q  <= addr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
    way_q   <= way_d;
    blk_q   <= blk_d;
  end

endmodule
